// File: rtl/axi_pwm_gen_core_if.sv
// Configuration / waveform bundle between the axi_pwm register slave and the
// PWM generator core.
//   master : register side, drives CTRL_EN, CTRL_POL, PERIOD, DUTY, CFG_WR
//            and observes CFG_PENDING, PWM_OUT, PERIOD_TICK, CNT_VAL
//   slave  : generator core, the mirror image of master
interface axi_pwm_gen_core_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32
);
    logic                    CTRL_EN;
    logic [NUM_CH-1:0]       CTRL_POL;
    logic [CNT_W-1:0]        PERIOD;
    logic [NUM_CH*CNT_W-1:0] DUTY;
    logic                    CFG_WR;
    logic                    CFG_PENDING;
    logic [NUM_CH-1:0]       PWM_OUT;
    logic                    PERIOD_TICK;
    logic [CNT_W-1:0]        CNT_VAL;

    modport master (
        output CTRL_EN, CTRL_POL, PERIOD, DUTY, CFG_WR,
        input  CFG_PENDING, PWM_OUT, PERIOD_TICK, CNT_VAL
    );

    modport slave (
        input  CTRL_EN, CTRL_POL, PERIOD, DUTY, CFG_WR,
        output CFG_PENDING, PWM_OUT, PERIOD_TICK, CNT_VAL
    );
endinterface

// File: rtl/axi_pwm_gen_core.sv
// Multi-channel PWM generator. One period counter is shared by NUM_CH
// channels; each channel compares the counter against its own duty value.
// Writes to PERIOD/DUTY made while running are staged and only become active
// at a period boundary, so no period is ever cut short or stretched.
// Ports:
//   ACLK   : clock, all logic on the rising edge
//   ARESET : synchronous active-high reset
//   bus    : slave modport of axi_pwm_gen_core_if (controls in, waveforms out)
module axi_pwm_gen_core #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32
) (
    input  logic              ACLK,
    input  logic              ARESET,
    axi_pwm_gen_core_if.slave bus
);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [NUM_CH-1:0] CH_ZERO  = {NUM_CH{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  act_period_r;
    logic [CNT_W-1:0]  stg_period_r;
    logic [CNT_W-1:0]  act_duty_r [NUM_CH];
    logic [CNT_W-1:0]  stg_duty_r [NUM_CH];
    logic              pending_r;
    logic [NUM_CH-1:0] pwm_r;

    logic              run_s;
    logic              boundary_s;
    logic [NUM_CH-1:0] raw_s;

    // Edge classification and per-channel compare against the live counter
    always_comb begin
        // Only an edge that is already in RUN with enable still high advances
        // the counter; the IDLE->RUN edge itself still behaves as IDLE so the
        // first RUN cycle starts at cnt = 0.
        run_s      = (state_r == ST_RUN) && bus.CTRL_EN;
        boundary_s = (state_r == ST_RUN) && (cnt_r == act_period_r);
        raw_s      = CH_ZERO;
        for (int i = 0; i < NUM_CH; i++) begin
            raw_s[i] = (cnt_r < act_duty_r[i]);
        end
    end

    // Control FSM, period counter, config staging and registered outputs
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            act_period_r <= CNT_ZERO;
            stg_period_r <= CNT_ZERO;
            pending_r    <= 1'b0;
            pwm_r        <= CH_ZERO;
            for (int i = 0; i < NUM_CH; i++) begin
                act_duty_r[i] <= CNT_ZERO;
                stg_duty_r[i] <= CNT_ZERO;
            end
        end else begin
            // Enable drops take effect on the same edge, from either state
            state_r <= bus.CTRL_EN ? ST_RUN : ST_IDLE;

            if (run_s) begin
                pwm_r <= raw_s ^ bus.CTRL_POL;
                if (boundary_s) begin
                    cnt_r <= CNT_ZERO;
                end else begin
                    cnt_r <= cnt_r + CNT_ONE;
                end

                if (boundary_s && bus.CFG_WR) begin
                    // Write lands exactly on the boundary: it becomes the
                    // next period directly and supersedes anything staged.
                    act_period_r <= bus.PERIOD;
                    for (int i = 0; i < NUM_CH; i++) begin
                        act_duty_r[i] <= bus.DUTY[i*CNT_W +: CNT_W];
                    end
                    pending_r <= 1'b0;
                end else if (boundary_s && pending_r) begin
                    act_period_r <= stg_period_r;
                    for (int i = 0; i < NUM_CH; i++) begin
                        act_duty_r[i] <= stg_duty_r[i];
                    end
                    pending_r <= 1'b0;
                end else if (bus.CFG_WR) begin
                    // Later writes simply overwrite the stage (last one wins)
                    stg_period_r <= bus.PERIOD;
                    for (int i = 0; i < NUM_CH; i++) begin
                        stg_duty_r[i] <= bus.DUTY[i*CNT_W +: CNT_W];
                    end
                    pending_r <= 1'b1;
                end else begin
                    pending_r <= pending_r;
                end
            end else begin
                // IDLE behaviour: counter parked, outputs at inactive level.
                // A stage left over from RUN survives unless overwritten here.
                cnt_r <= CNT_ZERO;
                pwm_r <= bus.CTRL_POL;
                if (bus.CFG_WR) begin
                    act_period_r <= bus.PERIOD;
                    for (int i = 0; i < NUM_CH; i++) begin
                        act_duty_r[i] <= bus.DUTY[i*CNT_W +: CNT_W];
                    end
                    pending_r <= 1'b0;
                end else begin
                    pending_r <= pending_r;
                end
            end
        end
    end

    assign bus.PWM_OUT     = pwm_r;
    assign bus.CFG_PENDING = pending_r;
    assign bus.CNT_VAL     = cnt_r;
    // Tick is decoded from the counter so it sits in the last count itself
    assign bus.PERIOD_TICK = boundary_s;
endmodule

// File: tb/tb_axi_pwm_gen_core.sv
// Scoreboard bench for axi_pwm_gen_core. A driver applies directed and
// random register traffic at the falling edge, advances a behavioural model
// and queues the expected outputs; a monitor checks them after each rising edge.
module tb_axi_pwm_gen_core;
    localparam int NUM_CH = 2;
    localparam int CNT_W  = 32;

    typedef struct packed {
        logic [31:0] per;
        logic [31:0] d0;
        logic [31:0] d1;
    } cfg_t;

    typedef struct packed {
        logic [1:0]  pwm;
        logic        tick;
        logic [31:0] cnt;
        logic        pend;
    } exp_t;

    logic ACLK;
    logic ARESET;

    axi_pwm_gen_core_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    axi_pwm_gen_core #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .bus    (bus.slave)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_tests = 0;
    int n_fail  = 0;

    // register-file image driven onto the bus
    logic        r_rst = 1'b1;
    logic        r_en  = 1'b0;
    logic [1:0]  r_pol = 2'b00;
    logic [31:0] r_per = 32'd0;
    logic [31:0] r_d0  = 32'd0;
    logic [31:0] r_d1  = 32'd0;

    // behavioural model state
    logic        m_run = 1'b0;
    logic [31:0] m_cnt = 32'd0;
    cfg_t        m_act = '0;
    cfg_t        m_stage_q[$];
    logic [1:0]  m_pwm = 2'b00;

    exp_t        exp_q[$];

    // waveform statistics gathered at falling edges
    int hi0 = 0;
    int hi1 = 0;
    int tks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // One clock of the reference behaviour, rules applied directly
    task automatic model_step(input logic wr);
        cfg_t w;
        exp_t e;
        w.per = r_per;
        w.d0  = r_d0;
        w.d1  = r_d1;
        if (r_rst) begin
            m_run = 1'b0;
            m_cnt = 32'd0;
            m_act = '0;
            m_stage_q.delete();
            m_pwm = 2'b00;
        end else begin
            if (m_run && r_en) begin
                m_pwm[0] = (m_cnt < m_act.d0) ^ r_pol[0];
                m_pwm[1] = (m_cnt < m_act.d1) ^ r_pol[1];
                if (m_cnt == m_act.per) begin
                    m_cnt = 32'd0;
                    if (wr) m_act = w;
                    else if (m_stage_q.size() != 0) m_act = m_stage_q[$];
                    m_stage_q.delete();
                end else begin
                    m_cnt = m_cnt + 32'd1;
                    if (wr) m_stage_q.push_back(w);
                end
            end else begin
                m_pwm = r_pol;
                m_cnt = 32'd0;
                if (wr) begin
                    m_act = w;
                    m_stage_q.delete();
                end
            end
            m_run = r_en;
        end
        e.pwm  = m_pwm;
        e.tick = m_run && (m_cnt == m_act.per);
        e.cnt  = m_cnt;
        e.pend = (m_stage_q.size() != 0);
        exp_q.push_back(e);
    endtask

    task automatic tick_cycle(input logic wr);
        @(negedge ACLK);
        hi0 += int'(bus.PWM_OUT[0]);
        hi1 += int'(bus.PWM_OUT[1]);
        tks += int'(bus.PERIOD_TICK);
        ARESET       = r_rst;
        bus.CTRL_EN  = r_en;
        bus.CTRL_POL = r_pol;
        bus.PERIOD   = r_per;
        bus.DUTY     = {r_d1, r_d0};
        bus.CFG_WR   = wr;
        model_step(wr);
    endtask

    task automatic run_until_cnt(input logic [31:0] target);
        int guard;
        guard = 0;
        while (m_cnt != target && guard < 100) begin
            tick_cycle(1'b0);
            guard++;
        end
        n_tests++;
        if (m_cnt != target) begin
            n_fail++;
            $display("FAIL wait_cnt: got %0d expected %0d (timeout)", m_cnt, target);
        end
    endtask

    task automatic count10();
        hi0 = 0;
        hi1 = 0;
        tks = 0;
        repeat (10) tick_cycle(1'b0);
    endtask

    // Monitor: every clock is an output beat; compare against the queue head
    initial begin
        exp_t e;
        forever begin
            @(posedge ACLK);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pwm_out",     32'(bus.PWM_OUT),     32'(e.pwm));
                chk("period_tick", 32'(bus.PERIOD_TICK), 32'(e.tick));
                chk("cnt_val",     bus.CNT_VAL,          e.cnt);
                chk("cfg_pending", 32'(bus.CFG_PENDING), 32'(e.pend));
            end
        end
    end

    // Driver
    initial begin
        logic wr;
        ARESET       = 1'b1;
        bus.CTRL_EN  = 1'b0;
        bus.CTRL_POL = 2'b00;
        bus.PERIOD   = 32'd0;
        bus.DUTY     = 64'd0;
        bus.CFG_WR   = 1'b0;

        // reset held three cycles
        repeat (3) tick_cycle(1'b0);
        r_rst = 1'b0;

        // basic PWM, configured while idle
        r_per = 32'd9; r_d0 = 32'd3; r_d1 = 32'd7;
        tick_cycle(1'b1);
        tick_cycle(1'b0);
        r_en = 1'b1;
        repeat (12) tick_cycle(1'b0);
        count10();
        chk("basic_hi0", 32'(hi0), 32'd3);
        chk("basic_hi1", 32'(hi1), 32'd7);
        chk("basic_tick", 32'(tks), 32'd1);

        // staged update mid-period
        run_until_cnt(32'd4);
        r_d0 = 32'd5;
        tick_cycle(1'b1);
        run_until_cnt(32'd0);
        run_until_cnt(32'd5);
        count10();
        chk("staged_hi0", 32'(hi0), 32'd5);

        // write on the boundary cycle
        run_until_cnt(32'd9);
        r_per = 32'd4;
        tick_cycle(1'b1);
        repeat (3) tick_cycle(1'b0);
        count10();
        chk("collide_tick", 32'(tks), 32'd2);

        // edge values
        r_per = 32'd9; r_d0 = 32'd0;
        tick_cycle(1'b1);
        run_until_cnt(32'd0);
        run_until_cnt(32'd5);
        count10();
        chk("duty0_hi0", 32'(hi0), 32'd0);

        r_d0 = 32'd20;
        tick_cycle(1'b1);
        run_until_cnt(32'd0);
        run_until_cnt(32'd5);
        count10();
        chk("dutybig_hi0", 32'(hi0), 32'd10);

        r_per = 32'd0;
        tick_cycle(1'b1);
        run_until_cnt(32'd0);
        tick_cycle(1'b0);
        count10();
        chk("per0_tick", 32'(tks), 32'd10);

        r_per = 32'd9; r_d0 = 32'd3;
        tick_cycle(1'b1);
        run_until_cnt(32'd5);
        r_pol = 2'b01;
        tick_cycle(1'b0);
        count10();
        chk("pol_hi0", 32'(hi0), 32'd7);
        r_pol = 2'b00;

        // abort by enable with a stage outstanding, then resume
        run_until_cnt(32'd3);
        r_d0 = 32'd6;
        tick_cycle(1'b1);
        run_until_cnt(32'd6);
        r_en = 1'b0;
        repeat (3) tick_cycle(1'b0);
        r_en = 1'b1;
        repeat (25) tick_cycle(1'b0);

        // abort by reset with a stage outstanding
        run_until_cnt(32'd3);
        r_d1 = 32'd2;
        tick_cycle(1'b1);
        run_until_cnt(32'd6);
        r_rst = 1'b1;
        tick_cycle(1'b0);
        r_rst = 1'b0;
        repeat (5) tick_cycle(1'b0);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            r_rst = ($urandom_range(0, 199) == 0);
            r_en  = ($urandom_range(0, 99) < 97);
            if ($urandom_range(0, 19) == 0) r_pol = 2'($urandom_range(0, 3));
            wr = ($urandom_range(0, 9) == 0);
            if (wr) begin
                r_per = 32'($urandom_range(0, 15));
                r_d0  = 32'($urandom_range(0, 20));
                r_d1  = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 20));
            end
            tick_cycle(wr);
        end

        // drain the scoreboard
        repeat (3) @(negedge ACLK);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
